sort_drain: RTL and testbench

- Read-side companion to the 32-entry sort register bank.
- On `start`, takes a snapshot of all N sorted entries (s1..sN, s1 at the lowest slice) from a flattened bus.
- Streams the entries out one per transfer, in rank order (s1 first), over a valid/ready handshake.
- Pulses `done` after the last entry. Feeds the downstream output and packing logic of the image-sorting engine.

---
 rtl/sort_drain.sv | 147 ++++++++++++++
 tb/tb_sort_drain.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sort_drain.sv
// sort_drain: snapshots a sorted N-entry bank on start and streams it out in
// rank order over a valid/ready handshake, pulsing done after the last entry.
// Optional key-ordering monitor: define SORT_DRAIN_ORDER_CHECK_EN.
module sort_drain #(
  parameter int unsigned N  = 32,
  parameter int unsigned W  = 29,
  parameter int unsigned RW = 5,
  parameter int unsigned KW = 24
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [N*W-1:0]    s_flat,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [W-1:0]      out_data,
  output logic [RW-1:0]     out_rank,
  output logic              out_last,
  output logic              busy,
  output logic              done,
  output logic              order_err
);

  localparam logic [RW-1:0] LAST_RANK = RW'(N - 1);

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    DONE
  } state_t;

  state_t                 state, state_d;
  logic [N-1:0][W-1:0]    buffer, buffer_d;
  logic                   valid_d;
  logic [W-1:0]           data_d;
  logic [RW-1:0]          rank_d;
  logic [RW-1:0]          rank_inc;
  logic                   last_d;
  logic                   busy_d;
  logic                   done_d;
  logic                   xfer;

  assign xfer     = (state == STREAM) && out_valid && out_ready;
  assign rank_inc = out_rank + RW'(1);

  // Next-state and next-output decode
  always_comb begin
    state_d  = state;
    buffer_d = buffer;
    valid_d  = out_valid;
    data_d   = out_data;
    rank_d   = out_rank;
    last_d   = out_last;
    busy_d   = busy;
    done_d   = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          buffer_d = s_flat;
          state_d  = STREAM;
          rank_d   = '0;
          valid_d  = 1'b1;
          data_d   = s_flat[W-1:0];
          last_d   = (LAST_RANK == '0);
          busy_d   = 1'b1;
        end
      end
      STREAM: begin
        if (xfer) begin
          if (out_last) begin
            state_d = DONE;
            valid_d = 1'b0;
            busy_d  = 1'b0;
            last_d  = 1'b0;
            data_d  = '0;
            rank_d  = '0;
            done_d  = 1'b1;
          end else begin
            rank_d = rank_inc;
            data_d = buffer[rank_inc];
            last_d = (rank_inc == LAST_RANK);
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, snapshot buffer and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      buffer    <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_rank  <= '0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_d;
      buffer    <= buffer_d;
      out_valid <= valid_d;
      out_data  <= data_d;
      out_rank  <= rank_d;
      out_last  <= last_d;
      busy      <= busy_d;
      done      <= done_d;
    end
  end

`ifdef SORT_DRAIN_ORDER_CHECK_EN
  logic [KW-1:0] prev_key;
  logic          order_err_d;

  // Sticky flag when a transferred key is smaller than its predecessor
  always_comb begin
    order_err_d = order_err;
    if ((state == IDLE) && start) begin
      order_err_d = 1'b0;
    end else if (xfer && (out_rank != '0) && (out_data[KW-1:0] < prev_key)) begin
      order_err_d = 1'b1;
    end
  end

  // Previous-key register and error flag
  always_ff @(posedge clk) begin
    if (reset) begin
      prev_key  <= '0;
      order_err <= 1'b0;
    end else begin
      if (xfer) begin
        prev_key <= out_data[KW-1:0];
      end
      order_err <= order_err_d;
    end
  end
`else
  assign order_err = 1'b0;
`endif

endmodule

// File: tb/tb_sort_drain.sv
// Self-checking bench for sort_drain: scoreboard of expected {rank,data}
// pushed at start, popped on every observed transfer.
module tb_sort_drain;

  localparam int unsigned N  = 32;
  localparam int unsigned W  = 29;
  localparam int unsigned RW = 5;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [N*W-1:0]    s_flat;
  logic              out_ready;
  logic              out_valid;
  logic [W-1:0]      out_data;
  logic [RW-1:0]     out_rank;
  logic              out_last;
  logic              busy;
  logic              done;
  logic              order_err;

  sort_drain #(.N(N), .W(W), .RW(RW), .KW(24)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .s_flat    (s_flat),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_rank  (out_rank),
    .out_last  (out_last),
    .busy      (busy),
    .done      (done),
    .order_err (order_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int xfers  = 0;
  int dones  = 0;
  logic [RW+W-1:0] sb[$];
  logic [W-1:0]    bank [N];
  logic            stalled = 1'b0;
  logic [W-1:0]    held_data;
  logic [RW-1:0]   held_rank;

  function automatic logic [W-1:0] mk(input int k);
    logic [W-1:0] e;
    e = {5'(k), 2'b00, 6'd1, 8'(k + 1), 8'd0};
    return e;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic sorted_bank();
    for (int k = 0; k < N; k++) bank[k] = mk(k);
  endtask

  task automatic drive_bank();
    for (int k = 0; k < N; k++) s_flat[k*W +: W] = bank[k];
  endtask

  task automatic push_bank();
    for (int k = 0; k < N; k++) sb.push_back({RW'(k), bank[k]});
  endtask

  // Observe the current cycle (transfer decided by rdy) then advance one cycle
  task automatic tick(input logic rdy);
    logic [RW+W-1:0] exp;
    out_ready = rdy;
    if (stalled) begin
      chk("hold_data", 64'(out_data), 64'(held_data));
      chk("hold_rank", 64'(out_rank), 64'(held_rank));
    end
    if (out_valid) chk("last_flag", 64'(out_last), 64'(out_rank == RW'(N - 1)));
    if (out_valid && rdy) begin
      if (sb.size() == 0) begin
        chk("sb_underflow", 64'(sb.size()), 64'd1);
      end else begin
        exp = sb.pop_front();
        chk("xfer_rank_data", 64'({out_rank, out_data}), 64'(exp));
      end
      xfers++;
    end
    stalled   = out_valid && !rdy;
    held_data = out_data;
    held_rank = out_rank;
    if (done) dones++;
    @(negedge clk);
  endtask

  // Start a stream from the current bank and advance into the first cycle
  task automatic kick();
    xfers = 0;
    dones = 0;
    drive_bank();
    start = 1'b1;
    push_bank();
    tick(1'b0);
    start = 1'b0;
  endtask

  // Drain with a ready pattern until the done cycle (bounded)
  task automatic run_stream(input int mode, input int budget);
    int cyc = 0;
    while (!done && cyc < budget) begin
      tick(mode == 0 ? 1'b1 : ((cyc % 3) == 0));
      cyc++;
    end
    chk("done_seen", 64'(done), 64'd1);
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_valid"}, 64'(out_valid), 64'd0);
    chk({tag, "_busy"},  64'(busy),      64'd0);
    chk({tag, "_done"},  64'(done),      64'd0);
    chk({tag, "_data"},  64'(out_data),  64'd0);
    chk({tag, "_rank"},  64'(out_rank),  64'd0);
    chk({tag, "_last"},  64'(out_last),  64'd0);
    chk({tag, "_oerr"},  64'(order_err), 64'd0);
  endtask

  initial begin
    int cyc;
    logic pulsed;
    reset = 1'b1;
    start = 1'b0;
    out_ready = 1'b0;
    sorted_bank();
    drive_bank();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Reset then idle
    for (int i = 0; i < 5; i++) begin
      check_idle("idle");
      tick(1'b0);
    end

    // Full stream, ready always high
    kick();
    chk("t1_valid", 64'(out_valid), 64'd1);
    chk("t1_busy",  64'(busy),      64'd1);
    chk("t1_rank",  64'(out_rank),  64'd0);
    chk("t1_data",  64'(out_data),  64'(29'b00000_00_000001_00000001_00000000));
    for (int i = 0; i < 32; i++) tick(1'b1);
    chk("t33_done",  64'(done),      64'd1);
    chk("t33_busy",  64'(busy),      64'd0);
    chk("t33_valid", 64'(out_valid), 64'd0);
    chk("full_xfers", 64'(xfers),    64'd32);
    tick(1'b1);
    chk("t34_done",   64'(done),     64'd0);
    chk("full_dones", 64'(dones),    64'd1);
    chk("full_sb",    64'(sb.size()), 64'd0);
    chk("full_oerr",  64'(order_err), 64'd0);

    // Backpressure 1,0,0 pattern
    kick();
    run_stream(1, 200);
    tick(1'b1);
    chk("bp_xfers", 64'(xfers),     64'd32);
    chk("bp_dones", 64'(dones),     64'd1);
    chk("bp_sb",    64'(sb.size()), 64'd0);

    // Snapshot isolation and start-ignore while busy / in DONE
    kick();
    s_flat[5*W +: W] = '1;
    pulsed = 1'b0;
    cyc = 0;
    while (!done && cyc < 100) begin
      start = out_valid && (out_rank == RW'(10)) && !pulsed;
      if (start) pulsed = 1'b1;
      tick(1'b1);
      start = 1'b0;
      cyc++;
    end
    chk("snap_done", 64'(done), 64'd1);
    start = 1'b1;
    tick(1'b1);
    start = 1'b0;
    chk("snap_no_restart_valid", 64'(out_valid), 64'd0);
    chk("snap_no_restart_busy",  64'(busy),      64'd0);
    chk("snap_xfers", 64'(xfers),     64'd32);
    chk("snap_dones", 64'(dones),     64'd1);
    chk("snap_sb",    64'(sb.size()), 64'd0);

    // Reset mid-stream at rank 7
    kick();
    cyc = 0;
    while (!(out_valid && out_rank == RW'(7)) && cyc < 50) begin
      tick(1'b1);
      cyc++;
    end
    chk("rst_reach7", 64'(out_rank), 64'd7);
    out_ready = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    stalled = 1'b0;
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_busy",  64'(busy),      64'd0);
    sb.delete();
    for (int i = 0; i < 5; i++) tick(1'b1);
    chk("rst_no_done", 64'(dones), 64'd0);
    kick();
    chk("rst_restart_rank", 64'(out_rank), 64'd0);
    run_stream(0, 100);
    tick(1'b1);
    chk("rst_restart_xfers", 64'(xfers),     64'd32);
    chk("rst_restart_sb",    64'(sb.size()), 64'd0);

`ifdef SORT_DRAIN_ORDER_CHECK_EN
    // Swapped ranks 12/13 raise a sticky order error after the rank-13 transfer
    sorted_bank();
    bank[12] = mk(13);
    bank[13] = mk(12);
    kick();
    cyc = 0;
    while (!done && cyc < 100) begin
      if (out_valid) chk("oerr_run", 64'(order_err), 64'(out_rank > RW'(13)));
      tick(1'b1);
      cyc++;
    end
    chk("oerr_done", 64'(order_err), 64'd1);
    for (int i = 0; i < 3; i++) tick(1'b0);
    chk("oerr_sticky", 64'(order_err), 64'd1);

    // Sorted bank with equal keys at ranks 3 and 4 stays clean
    sorted_bank();
    bank[4] = {5'd4, bank[3][23:0]};
    kick();
    chk("oerr_cleared", 64'(order_err), 64'd0);
    cyc = 0;
    while (!done && cyc < 100) begin
      if (out_valid) chk("oerr_eq_run", 64'(order_err), 64'd0);
      tick(1'b1);
      cyc++;
    end
    tick(1'b1);
    chk("oerr_eq_end", 64'(order_err), 64'd0);
    chk("oerr_eq_sb",  64'(sb.size()), 64'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
